// File: rtl/em_run_ctrl_pkg.sv
// Shared types and defaults for the EDUC-8 front-panel run/halt/step controller.
// State encodings are fixed so the panel lamps and any debug tap read the same values.
package em_run_ctrl_pkg;

   typedef enum logic [1:0] {
      StHalted = 2'd0,
      StRun    = 2'd1,
      StStep   = 2'd2
   } run_state_e;

   localparam int unsigned DefDebounceCycles = 16;
   localparam int unsigned DefDbW            = 5;

   // Decides, at a sampled rco, whether the timing chain stops on this cycle boundary.
   function automatic logic stop_at_rco(input run_state_e st,
                                        input logic       halt_pend,
                                        input logic       instr_end,
                                        input logic       hlt_op,
                                        input logic       step_inst);
      logic stop;
      stop = 1'b0;
      unique case (st)
         StRun:   stop = halt_pend | (instr_end & hlt_op);
         StStep:  stop = ~step_inst | instr_end | halt_pend;
         default: stop = 1'b1;
      endcase
      return stop;
   endfunction

endpackage

// File: rtl/em_run_ctrl_debounce.sv
// Two-flop synchroniser plus stability counter for one panel switch.
// The debounced level resets to 1 so a switch held through reset must be re-pressed.
module em_run_ctrl_debounce
   import em_run_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned DB_W            = DefDbW
) (
   input  logic clk,
   input  logic clr,
   input  logic raw,
   output logic db
);

   localparam logic [DB_W-1:0] CntLast = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            db_q;
   logic            db_d;
   logic [DB_W-1:0] cnt_q;
   logic [DB_W-1:0] cnt_d;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         db_q    <= 1'b1;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   // Counter runs only while the synchronised level disagrees with the accepted one.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q) begin
         if (cnt_q == CntLast) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign db = db_q;

endmodule

// File: rtl/em_run_ctrl.sv
// Run/halt/single-step controller gating the em_74161 timing counter.
// Stops are taken only on the 15->0 wrap so the machine never halts mid-cycle.
module em_run_ctrl
   import em_run_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned DB_W            = DefDbW
) (
   input  logic clk,
   input  logic clr,
   input  logic run_sw,
   input  logic halt_sw,
   input  logic step_sw,
   input  logic step_inst,
   input  logic rco,
   input  logic instr_end,
   input  logic hlt_op,
   output logic cnt_en,
   output logic running,
   output logic halted,
   output logic cycle_done
);

   logic       run_db;
   logic       halt_db;
   logic       step_db;
   logic       run_prev_q;
   logic       step_prev_q;
   logic       run_rise;
   logic       step_rise;
   logic       rco_valid;
   logic       halt_pend_q;
   logic       halt_pend_d;
   logic       cycle_done_q;
   run_state_e state_q;
   run_state_e state_d;

   em_run_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
   ) u_run_db (
      .clk(clk),
      .clr(clr),
      .raw(run_sw),
      .db (run_db)
   );

   em_run_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
   ) u_halt_db (
      .clk(clk),
      .clr(clr),
      .raw(halt_sw),
      .db (halt_db)
   );

   em_run_ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
   ) u_step_db (
      .clk(clk),
      .clr(clr),
      .raw(step_sw),
      .db (step_db)
   );

   assign run_rise  = run_db & ~run_prev_q;
   assign step_rise = step_db & ~step_prev_q;
   assign rco_valid = rco & cnt_en;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= StHalted;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHalted: begin
            if (!halt_db) begin
               if (run_rise) begin
                  state_d = StRun;
               end else if (step_rise) begin
                  state_d = StStep;
               end
            end
         end
         StRun, StStep: begin
            if (rco_valid && stop_at_rco(state_q, halt_pend_q, instr_end, hlt_op, step_inst)) begin
               state_d = StHalted;
            end
         end
         default: state_d = StHalted;
      endcase
   end

   always_comb begin
      cnt_en     = (state_q == StRun) || (state_q == StStep);
      running    = (state_q == StRun) || (state_q == StStep);
      halted     = (state_q == StHalted);
      cycle_done = cycle_done_q;
   end

   // A brief HALT press must survive until the next cycle boundary.
   always_comb begin
      halt_pend_d = 1'b0;
      if (cnt_en && (state_d != StHalted)) begin
         halt_pend_d = halt_pend_q | halt_db;
      end
   end

   // Previous levels reset to 1 so a debounced level of 1 out of reset is not an edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         run_prev_q   <= 1'b1;
         step_prev_q  <= 1'b1;
         halt_pend_q  <= 1'b0;
         cycle_done_q <= 1'b0;
      end else begin
         run_prev_q   <= run_db;
         step_prev_q  <= step_db;
         halt_pend_q  <= halt_pend_d;
         cycle_done_q <= rco_valid;
      end
   end

endmodule

// File: tb/tb_em_run_ctrl.sv
// Self-checking bench for em_run_ctrl driving a behavioural 4-bit timing counter.
module tb_em_run_ctrl;

   localparam int unsigned DbCycles = 4;
   localparam int unsigned DbW      = 3;
   localparam int          StartLat = DbCycles + 3;

   logic       clk       = 1'b0;
   logic       clr       = 1'b1;
   logic       run_sw    = 1'b0;
   logic       halt_sw   = 1'b0;
   logic       step_sw   = 1'b0;
   logic       step_inst = 1'b0;
   logic       instr_end;
   logic       hlt_op;
   logic       rco;
   logic       cnt_en;
   logic       running;
   logic       halted;
   logic       cycle_done;
   logic [3:0] cnt       = 4'd0;

   int   checks  = 0;
   int   errors  = 0;
   int   cyc_cnt = 0;
   logic cyc_rst = 1'b0;
   logic ie_on   = 1'b0;
   logic hlt_on  = 1'b0;
   int   ie_cyc  = 1;

   em_run_ctrl #(
      .DEBOUNCE_CYCLES(DbCycles),
      .DB_W           (DbW)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .run_sw    (run_sw),
      .halt_sw   (halt_sw),
      .step_sw   (step_sw),
      .step_inst (step_inst),
      .rco       (rco),
      .instr_end (instr_end),
      .hlt_op    (hlt_op),
      .cnt_en    (cnt_en),
      .running   (running),
      .halted    (halted),
      .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   // Timing counter stand-in: counts while enabled, cleared by the shared reset.
   always @(posedge clk or posedge clr) begin
      if (clr) cnt <= 4'd0;
      else if (cnt_en) cnt <= cnt + 4'd1;
   end
   assign rco = (cnt == 4'd15) && cnt_en;

   always @(posedge clk) begin
      if (cyc_rst) cyc_cnt <= 0;
      else if (rco) cyc_cnt <= cyc_cnt + 1;
   end

   // Instruction-length model: instr_end only on the chosen 1-based cycle.
   assign instr_end = ie_on && ((cyc_cnt + 1) == ie_cyc);
   assign hlt_op    = hlt_on;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (cnt_en === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_until_halt(input int budget, output int edges, output int dones,
                                 output bit timeout);
      edges   = 0;
      dones   = 0;
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cycle_done === 1'b1) dones++;
         if (halted === 1'b1) begin
            timeout = 1'b0;
            break;
         end
         edges++;
      end
   endtask

   task automatic clear_cycles();
      cyc_rst = 1'b1;
      tick();
      cyc_rst = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({cnt_en, running, halted, cycle_done} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_outputs: got en/run/hlt/done=%b expected 0010",
                  {cnt_en, running, halted, cycle_done});
      end
      tick();
      clr = 1'b0;
      repeat (8) tick();
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || cnt_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got halted=%b cnt_en=%b expected 1/0", halted, cnt_en);
      end
      tick();
   endtask

   task automatic test_run_start();
      int lat;
      int bad;
      int dones;
      logic [3:0] exp_cnt;
      run_sw = 1'b1;
      wait_start(lat);
      checks++;
      if (lat != StartLat) begin
         errors++;
         $display("FAIL run_latency: got %0d edges expected %0d", lat, StartLat);
      end
      checks++;
      if (cnt !== 4'd0) begin
         errors++;
         $display("FAIL run_start_count: got %0d expected 0", cnt);
      end
      run_sw  = 1'b0;
      bad     = 0;
      dones   = 0;
      exp_cnt = 4'd0;
      for (int i = 0; i < 37; i++) begin
         tick();
         exp_cnt = exp_cnt + 4'd1;
         if (cnt !== exp_cnt) bad++;
         if (cycle_done === 1'b1) dones++;
      end
      checks++;
      if (bad != 0 || dones != 2 || cnt_en !== 1'b1) begin
         errors++;
         $display("FAIL run_counting: got %0d miscounts, %0d dones, en=%b expected 0, 2, 1",
                  bad, dones, cnt_en);
      end
   endtask

   task automatic test_halt_boundary();
      int edges;
      int dones;
      bit to;
      checks++;
      if (cnt !== 4'd5) begin
         errors++;
         $display("FAIL halt_setup_count: got %0d expected 5", cnt);
      end
      halt_sw = 1'b1;
      repeat (6) tick();
      halt_sw = 1'b0;
      checks++;
      if (cnt_en !== 1'b1) begin
         errors++;
         $display("FAIL halt_midcycle: got cnt_en=%b expected 1", cnt_en);
      end
      run_until_halt(64, edges, dones, to);
      checks++;
      if (to || edges != 5 || dones != 1 || cnt !== 4'd0) begin
         errors++;
         $display("FAIL halt_wrap: got timeout=%0d edges=%0d dones=%0d cnt=%0d expected 0 5 1 0",
                  to, edges, dones, cnt);
      end
      repeat (5) tick();
      checks++;
      if (cnt !== 4'd0 || halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_rest: got cnt=%0d halted=%b expected 0/1", cnt, halted);
      end
      repeat (10) tick();
   endtask

   task automatic test_step_cycle();
      int lat;
      int edges;
      int dones;
      bit to;
      step_inst = 1'b0;
      step_sw   = 1'b1;
      wait_start(lat);
      checks++;
      if (lat != StartLat) begin
         errors++;
         $display("FAIL step_latency: got %0d expected %0d", lat, StartLat);
      end
      run_until_halt(64, edges, dones, to);
      checks++;
      if (to || edges != 16 || dones != 1 || cnt !== 4'd0) begin
         errors++;
         $display("FAIL step_cycle: got timeout=%0d edges=%0d dones=%0d cnt=%0d expected 0 16 1 0",
                  to, edges, dones, cnt);
      end
      repeat (30) tick();
      checks++;
      if (halted !== 1'b1 || cnt !== 4'd0) begin
         errors++;
         $display("FAIL step_held: got halted=%b cnt=%0d expected 1/0", halted, cnt);
      end
      step_sw = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_step_inst();
      int lat;
      int edges;
      int dones;
      bit to;
      clear_cycles();
      step_inst = 1'b1;
      ie_on     = 1'b1;
      ie_cyc    = 3;
      step_sw   = 1'b1;
      wait_start(lat);
      step_sw = 1'b0;
      run_until_halt(200, edges, dones, to);
      checks++;
      if (to || edges != 48 || dones != 3) begin
         errors++;
         $display("FAIL step_inst: got timeout=%0d edges=%0d dones=%0d expected 0 48 3",
                  to, edges, dones);
      end
      ie_on     = 1'b0;
      step_inst = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_hlt_op();
      int lat;
      int edges;
      int dones;
      bit to;
      clear_cycles();
      ie_on  = 1'b1;
      ie_cyc = 2;
      hlt_on = 1'b1;
      run_sw = 1'b1;
      wait_start(lat);
      run_sw = 1'b0;
      run_until_halt(200, edges, dones, to);
      checks++;
      if (to || edges != 32 || dones != 2) begin
         errors++;
         $display("FAIL hlt_op: got timeout=%0d edges=%0d dones=%0d expected 0 32 2",
                  to, edges, dones);
      end
      ie_on  = 1'b0;
      hlt_on = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_glitch();
      run_sw = 1'b1;
      repeat (2) tick();
      run_sw = 1'b0;
      repeat (20) tick();
      checks++;
      if (halted !== 1'b1 || cnt_en !== 1'b0) begin
         errors++;
         $display("FAIL run_glitch: got halted=%b cnt_en=%b expected 1/0", halted, cnt_en);
      end
   endtask

   task automatic test_clr_hold();
      int lat;
      run_sw = 1'b1;
      tick();
      clr = 1'b1;
      repeat (3) tick();
      clr = 1'b0;
      repeat (20) tick();
      checks++;
      if (halted !== 1'b1 || cnt_en !== 1'b0) begin
         errors++;
         $display("FAIL clr_hold: got halted=%b cnt_en=%b expected 1/0", halted, cnt_en);
      end
      run_sw = 1'b0;
      repeat (10) tick();
      run_sw = 1'b1;
      wait_start(lat);
      run_sw = 1'b0;
      checks++;
      if (lat != StartLat) begin
         errors++;
         $display("FAIL clr_repress: got latency %0d expected %0d", lat, StartLat);
      end
      for (int i = 0; i < 40 && cnt != 4'd9; i++) tick();
      #2;
      clr = 1'b1;
      #1;
      checks++;
      if (cnt_en !== 1'b0 || halted !== 1'b1 || running !== 1'b0) begin
         errors++;
         $display("FAIL clr_async: got en=%b halted=%b running=%b expected 0/1/0",
                  cnt_en, halted, running);
      end
      tick();
      clr = 1'b0;
      repeat (10) tick();
   endtask

   // Reference: number of whole cycles a session lasts, from the panel rules alone.
   function automatic int exp_cycles(input int mode, input int n);
      if (mode == 2) return 1;
      return n;
   endfunction

   task automatic test_random();
      int mode;
      int n;
      int c;
      int lat;
      int edges;
      int dones;
      int exp;
      bit to;
      for (int it = 0; it < 8; it++) begin
         mode = $urandom_range(0, 3);
         n    = $urandom_range(1, 4);
         c    = $urandom_range(0, 5);
         exp  = exp_cycles(mode, n);
         clear_cycles();
         ie_cyc    = n;
         ie_on     = (mode == 0) || (mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1));
         hlt_on    = (mode == 0);
         step_inst = (mode == 1);
         if (mode == 0 || mode == 3) run_sw = 1'b1;
         else step_sw = 1'b1;
         wait_start(lat);
         run_sw  = 1'b0;
         step_sw = 1'b0;
         if (mode == 3) begin
            for (int i = 0; i < 200 && !(cyc_cnt == n - 1 && cnt == c[3:0]); i++) tick();
            halt_sw = 1'b1;
            repeat (6) tick();
            halt_sw = 1'b0;
         end
         run_until_halt(300, edges, dones, to);
         checks++;
         if (to || cyc_cnt != exp || cnt !== 4'd0) begin
            errors++;
            $display("FAIL rand_%0d mode %0d: got timeout=%0d cycles=%0d cnt=%0d expected 0 %0d 0",
                     it, mode, to, cyc_cnt, cnt, exp);
         end
         if (mode != 3) begin
            checks++;
            if (edges != 16 * exp || dones != exp) begin
               errors++;
               $display("FAIL rand_%0d counts: got edges=%0d dones=%0d expected %0d %0d",
                        it, edges, dones, 16 * exp, exp);
            end
         end
         ie_on     = 1'b0;
         hlt_on    = 1'b0;
         step_inst = 1'b0;
         repeat (15) tick();
      end
   endtask

   initial begin
      test_reset();
      test_run_start();
      test_halt_boundary();
      test_step_cycle();
      test_step_inst();
      test_hlt_op();
      test_glitch();
      test_clr_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
